rv32_stream_loader: RTL and testbench

Bus initiator that drives the picorv32-style native memory bus from the master side. It packs an incoming byte stream into little-endian 32-bit words and writes them to consecutive word addresses starting at `BASE_ADDR`, with optional read-back verification of each word. It sits in front of the address arbiter in place of, or muxed with, the CPU, and loads program RAM over a serial or debug link.

---
 rtl/rv32_stream_loader.sv | 158 +++++++++++++++
 tb/tb_rv32_stream_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_stream_loader.sv
// Packs a byte stream into little-endian words and writes them over the native
// memory bus to consecutive addresses, optionally reading each word back to compare.
module rv32_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned N_WORDS   = 16384,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  output logic                           rv32_valid,
  input  logic                           rv32_ready,
  output logic [31:0]                    rv32_addr,
  output logic [31:0]                    rv32_wdata,
  output logic [3:0]                     rv32_wstrb,
  input  logic [31:0]                    rv32_rdata,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(N_WORDS+1)-1:0]   words_written
);

  localparam int unsigned CW = $clog2(N_WORDS + 1);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_WRITE,
    S_GAP,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          accept;
  logic          hs;
  logic [CW-1:0] cnt_inc;
  logic          last_word;

  assign in_ready  = (state_q == S_COLLECT) && !reset;
  assign accept    = in_valid && in_ready;
  assign hs        = valid_q && rv32_ready;
  assign cnt_inc   = cnt_q + CW'(1);
  assign last_word = (cnt_inc == CW'(N_WORDS));

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = done_q;
    error_d = error_q;

    unique case (state_q)
      S_COLLECT: begin
        if (accept) begin
          buf_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            valid_d = 1'b1;
            addr_d  = BASE_ADDR + (32'(cnt_q) << 2);
            wdata_d = buf_d;
            wstrb_d = 4'hf;
          end
        end
      end
      S_WRITE: begin
        if (hs) begin
          valid_d = 1'b0;
          if (VERIFY_EN) begin
            state_d = S_GAP;
          end else begin
            cnt_d   = cnt_inc;
            state_d = last_word ? S_DONE : S_COLLECT;
            done_d  = last_word;
          end
        end
      end
      S_GAP: begin
        state_d = S_VERIFY;
        valid_d = 1'b1;
        wstrb_d = 4'h0;
      end
      S_VERIFY: begin
        if (hs) begin
          valid_d = 1'b0;
          if (rv32_rdata != wdata_q) error_d = 1'b1;
          cnt_d   = cnt_inc;
          state_d = last_word ? S_DONE : S_COLLECT;
          done_d  = last_word;
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
      end
      default: state_d = S_COLLECT;
    endcase

    busy_d = (idx_d != 2'd0) || (state_d == S_WRITE) || (state_d == S_GAP)
             || (state_d == S_VERIFY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_COLLECT;
      idx_q   <= 2'd0;
      buf_q   <= 32'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign rv32_valid    = valid_q;
  assign rv32_addr     = addr_q;
  assign rv32_wdata    = wdata_q;
  assign rv32_wstrb    = wstrb_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_rv32_stream_loader.sv
// Scoreboard bench: two loader instances (write-only with address wrap, and
// write+verify) driven by a byte source and a per-instance bus responder model.
module tb_rv32_stream_loader;

  typedef struct packed {
    logic [0:0]  dut;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xact_t;

  localparam logic [31:0] BASE0 = 32'hffff_fffc;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid [2] = '{1'b0, 1'b0};
  logic [7:0]  in_data  [2] = '{8'h00, 8'h00};
  logic        in_ready [2];
  logic        rv_valid [2];
  logic        rv_ready [2] = '{1'b0, 1'b0};
  logic [31:0] rv_addr  [2];
  logic [31:0] rv_wdata [2];
  logic [3:0]  rv_wstrb [2];
  logic [31:0] rv_rdata [2] = '{32'd0, 32'd0};
  logic        busy     [2];
  logic        done     [2];
  logic        error    [2];
  logic [1:0]  ww0;
  logic [2:0]  ww1;

  int n_checks = 0;
  int n_fail   = 0;

  xact_t       exp_q [$];
  xact_t       resp_e;
  int          delay     [2] = '{0, 0};
  bit          stall     [2] = '{1'b0, 1'b0};
  int          wcnt      [2] = '{0, 0};
  bit          hs_pend   [2] = '{1'b0, 1'b0};
  logic [31:0] s_addr    [2];
  logic [31:0] s_wdata   [2];
  logic [3:0]  s_wstrb   [2];
  int          byte_idx  [2] = '{0, 0};
  logic [31:0] cur_word  [2] = '{32'd0, 32'd0};
  int          exp_words [2] = '{0, 0};
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'd0;

  always #5 clk = ~clk;

  rv32_stream_loader #(.BASE_ADDR(BASE0), .N_WORDS(2), .VERIFY_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .rv32_valid(rv_valid[0]), .rv32_ready(rv_ready[0]),
    .rv32_addr(rv_addr[0]), .rv32_wdata(rv_wdata[0]), .rv32_wstrb(rv_wstrb[0]),
    .rv32_rdata(rv_rdata[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
    .words_written(ww0)
  );

  rv32_stream_loader #(.BASE_ADDR(BASE1), .N_WORDS(4), .VERIFY_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .rv32_valid(rv_valid[1]), .rv32_ready(rv_ready[1]),
    .rv32_addr(rv_addr[1]), .rv32_wdata(rv_wdata[1]), .rv32_wstrb(rv_wstrb[1]),
    .rv32_rdata(rv_rdata[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
    .words_written(ww1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ww(input int d);
    return (d == 0) ? 32'(ww0) : 32'(ww1);
  endfunction

  // Bus responder and scoreboard consumer; ready is decided at the falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (hs_pend[d]) begin
        check("valid_after_hs", 32'(rv_valid[d]), 32'd0);
        hs_pend[d] = 1'b0;
      end
      rv_ready[d] = 1'b0;
      if (rv_valid[d]) begin
        if (wcnt[d] == 0) begin
          s_addr[d]  = rv_addr[d];
          s_wdata[d] = rv_wdata[d];
          s_wstrb[d] = rv_wstrb[d];
        end else begin
          check("hold_addr", rv_addr[d], s_addr[d]);
          check("hold_wdata", rv_wdata[d], s_wdata[d]);
          check("hold_wstrb", 32'(rv_wstrb[d]), 32'(s_wstrb[d]));
        end
        if (!stall[d] && wcnt[d] >= delay[d]) begin
          rv_ready[d] = 1'b1;
          wcnt[d]     = 0;
          hs_pend[d]  = 1'b1;
          check("xact_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            resp_e = exp_q.pop_front();
            check("xact_dut", 32'(d), 32'(resp_e.dut));
            check("xact_addr", rv_addr[d], resp_e.addr);
            check("xact_wdata", rv_wdata[d], resp_e.wdata);
            check("xact_wstrb", 32'(rv_wstrb[d]), 32'(resp_e.wstrb));
            rv_rdata[d] = (corrupt_en && resp_e.wstrb == 4'h0 && resp_e.addr == corrupt_addr)
                          ? 32'hdead_beef : resp_e.wdata;
          end
        end else begin
          wcnt[d]++;
        end
      end else begin
        wcnt[d] = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      byte_idx[d]  = 0;
      exp_words[d] = 0;
      cur_word[d]  = 32'd0;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // Offer one byte after `gap` idle cycles; push expected bus traffic on the 4th
  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    int    n;
    xact_t e;
    n = 0;
    for (int g = 0; g < gap; g++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = 8'($urandom);
      @(negedge clk);
    end
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    cur_word[d][8*byte_idx[d] +: 8] = b;
    if (byte_idx[d] == 3) begin
      e.dut   = 1'(d);
      e.addr  = ((d == 0) ? BASE0 : BASE1) + 32'(exp_words[d] * 4);
      e.wdata = cur_word[d];
      e.wstrb = 4'hf;
      exp_q.push_back(e);
      if (d == 1) begin
        e.wstrb = 4'h0;
        exp_q.push_back(e);
      end
      exp_words[d]++;
      byte_idx[d] = 0;
      @(negedge clk);
      check("valid_latency", 32'(rv_valid[d]), 32'd1);
      check("busy_in_write", 32'(busy[d]), 32'd1);
    end else begin
      byte_idx[d]++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rv_valid[d]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 300), 32'd1);
  endtask

  initial begin
    do_reset();
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(rv_valid[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_done", 32'(done[d]), 32'd0);
      check("rst_error", 32'(error[d]), 32'd0);
      check("rst_words", ww(d), 32'd0);
      check("rst_in_ready", 32'(in_ready[d]), 32'd1);
      check("rst_addr", rv_addr[d], 32'd0);
      check("rst_wdata", rv_wdata[d], 32'd0);
      check("rst_wstrb", 32'(rv_wstrb[d]), 32'd0);
    end

    // Gapless two-word load with zero-wait responder; second address wraps to 0
    for (int i = 0; i < 8; i++) send_byte(0, 8'((i + 1) * 17), 0);
    wait_drain(0);
    check("t1_done", 32'(done[0]), 32'd1);
    check("t1_words", ww(0), 32'd2);
    check("t1_in_ready", 32'(in_ready[0]), 32'd0);
    check("t1_busy", 32'(busy[0]), 32'd0);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_no_ninth", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0] = 1'b0;
    check("t1_words_hold", ww(0), 32'd2);

    // Responder stretches the write by three wait cycles
    do_reset();
    delay[0] = 3;
    for (int i = 0; i < 4; i++) send_byte(0, 8'(i + 1), 0);
    wait_drain(0);
    check("t2_in_ready", 32'(in_ready[0]), 32'd1);
    check("t2_words", ww(0), 32'd1);
    check("t2_busy", 32'(busy[0]), 32'd0);
    delay[0] = 0;

    // Reset with a partial word, then during a stalled write
    do_reset();
    send_byte(0, 8'h5a, 0);
    send_byte(0, 8'h5b, 1);
    check("t3_busy_partial", 32'(busy[0]), 32'd1);
    do_reset();
    check("t3a_valid", 32'(rv_valid[0]), 32'd0);
    check("t3a_busy", 32'(busy[0]), 32'd0);
    check("t3a_words", ww(0), 32'd0);
    stall[0] = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h30 + i), 0);
    repeat (2) @(negedge clk);
    check("t3_stalled_valid", 32'(rv_valid[0]), 32'd1);
    do_reset();
    stall[0] = 1'b0;
    check("t3b_valid", 32'(rv_valid[0]), 32'd0);
    check("t3b_busy", 32'(busy[0]), 32'd0);
    check("t3b_words", ww(0), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'ha1 + i), 0);
    wait_drain(0);
    check("t3_words", ww(0), 32'd1);

    // Verified load with random byte gaps; first read-back is corrupted
    delay[1]     = 1;
    corrupt_en   = 1'b1;
    corrupt_addr = BASE1;
    for (int i = 0; i < 16; i++) send_byte(1, 8'($urandom), int'($urandom_range(0, 5)));
    wait_drain(1);
    check("t4_done", 32'(done[1]), 32'd1);
    check("t4_error", 32'(error[1]), 32'd1);
    check("t4_words", ww(1), 32'd4);
    check("t4_in_ready", 32'(in_ready[1]), 32'd0);
    check("t4_busy", 32'(busy[1]), 32'd0);

    repeat (3) @(negedge clk);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
